// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the pipelined MIPS core: default
//                datapath widths, the bubble instruction and the IF/ID
//                pipeline record that the decode stage also consumes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int unsigned C_ADDR_W  = 32;
    localparam int unsigned C_INSTR_W = 32;

    // sll $0,$0,0 - architecturally a no-op, used to fill pipeline bubbles
    localparam logic [C_INSTR_W-1:0] C_NOP_INSTR = 32'h0000_0000;

    // IF/ID record at default widths; fields are ordered to match the flat
    // vector layout used inside fetch_stage {valid, instr, pc_plus1}.
    typedef struct packed {
        logic                 valid;
        logic [C_INSTR_W-1:0] instr;
        logic [C_ADDR_W-1:0]  pc_plus1;
    } if_id_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg
//  Description : Generic pipeline register. Synchronous reset clears to a
//                parameterised value; when i_en is low the contents hold,
//                when high i_d is loaded on the rising edge.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_en           - load enable (0 = hold)
//                i_d / o_q      - data in / registered data out
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter int unsigned        WIDTH   = 32,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (i_en) begin
            data_d = i_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_q = data_q;

endmodule : pipe_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch front end. Owns the PC, its increment and
//                the IF/ID register. Supports hazard stall, branch/jump
//                redirect with squash, halt/drain and saturating fetch/stall
//                counters. Edge priority: rst > redirect > stall > halt.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                imem_addr / imem_rdata   - instruction memory (comb read)
//                stall, redirect_valid,
//                redirect_target, halt    - control from hazard/branch units
//                id_valid, id_instr,
//                id_pc_plus1              - IF/ID register outputs
//                fetch_count, stall_count - performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned          ADDR_W    = C_ADDR_W,
    parameter int unsigned          INSTR_W   = C_INSTR_W,
    parameter int unsigned          PC_INC    = 1,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(C_NOP_INSTR),
    parameter int unsigned          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc_plus1,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   stall_count
);

    // IF/ID is kept as one flat vector {valid, instr, pc_plus1} so the same
    // generic register serves any ADDR_W/INSTR_W combination.
    localparam int unsigned         IFID_W   = 1 + INSTR_W + ADDR_W;
    localparam logic [IFID_W-1:0]   IFID_RST = {1'b0, NOP_INSTR, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              pc_en;
    logic [ADDR_W-1:0] pc_next_seq;

    logic [IFID_W-1:0] if_id_q;
    logic [IFID_W-1:0] if_id_d;
    logic              if_id_en;

    logic [CNT_W-1:0]  fetch_count_q;
    logic [CNT_W-1:0]  fetch_count_d;
    logic [CNT_W-1:0]  stall_count_q;
    logic [CNT_W-1:0]  stall_count_d;
    logic              fetch_inc;
    logic              stall_inc;

    // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap for free.
    assign pc_next_seq = pc_q + ADDR_W'(PC_INC);

    always_comb begin
        pc_d      = pc_q;
        pc_en     = 1'b1;
        if_id_d   = if_id_q;
        if_id_en  = 1'b1;
        fetch_inc = 1'b0;
        stall_inc = 1'b0;
        if (redirect_valid) begin
            // Squash the wrong-path fetch; pc_plus1 is left as-is.
            pc_d    = redirect_target;
            if_id_d = {1'b0, NOP_INSTR, if_id_q[ADDR_W-1:0]};
        end else if (stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            stall_inc = 1'b1;
        end else if (halt) begin
            // PC holds so fetch resumes at the same address on release.
            if_id_d = {1'b0, NOP_INSTR, if_id_q[ADDR_W-1:0]};
        end else begin
            pc_d      = pc_next_seq;
            if_id_d   = {1'b1, imem_rdata, pc_next_seq};
            fetch_inc = 1'b1;
        end
    end

    pipe_reg #(
        .WIDTH   (ADDR_W),
        .RST_VAL (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (pc_en),
        .i_d  (pc_d),
        .o_q  (pc_q)
    );

    pipe_reg #(
        .WIDTH   (IFID_W),
        .RST_VAL (IFID_RST)
    ) u_if_id_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (if_id_en),
        .i_d  (if_id_d),
        .o_q  (if_id_q)
    );

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (fetch_inc && (fetch_count_q != CNT_MAX)) begin
            fetch_count_d = fetch_count_q + 1'b1;
        end
        if (stall_inc && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_valid    = if_id_q[IFID_W-1];
    assign id_instr    = if_id_q[ADDR_W +: INSTR_W];
    assign id_pc_plus1 = if_id_q[ADDR_W-1:0];
    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. A default-width
//                instance runs a vector table; a narrow instance
//                (ADDR_W=4, CNT_W=3) covers PC wrap and counter saturation.
//                Instruction memory returns addr + 0x100.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default-width instance ----------------
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus1;
    logic [15:0] fetch_count;
    logic [15:0] stall_count;

    assign imem_rdata = imem_addr + 32'h100;

    fetch_stage u_dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc_plus1     (id_pc_plus1),
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
    );

    // ---------------- narrow instance ----------------
    logic        s_rst;
    logic        s_stall;
    logic        s_redirect_valid;
    logic [3:0]  s_redirect_target;
    logic        s_halt;
    logic [3:0]  s_imem_addr;
    logic [31:0] s_imem_rdata;
    logic        s_id_valid;
    logic [31:0] s_id_instr;
    logic [3:0]  s_id_pc_plus1;
    logic [2:0]  s_fetch_count;
    logic [2:0]  s_stall_count;

    assign s_imem_rdata = 32'h100 + {28'b0, s_imem_addr};

    fetch_stage #(
        .ADDR_W   (4),
        .CNT_W    (3),
        .RESET_PC (4'd13)
    ) u_dut_small (
        .clk             (clk),
        .rst             (s_rst),
        .imem_addr       (s_imem_addr),
        .imem_rdata      (s_imem_rdata),
        .stall           (s_stall),
        .redirect_valid  (s_redirect_valid),
        .redirect_target (s_redirect_target),
        .halt            (s_halt),
        .id_valid        (s_id_valid),
        .id_instr        (s_id_instr),
        .id_pc_plus1     (s_id_pc_plus1),
        .fetch_count     (s_fetch_count),
        .stall_count     (s_stall_count)
    );

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pcp1;
        logic [15:0] fc;
        logic [15:0] sc;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        halt;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[20];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic exp_t mk_e(input logic [31:0] pc, input logic v,
                                  input logic [31:0] instr, input logic [31:0] pcp1,
                                  input logic [15:0] fc, input logic [15:0] sc);
        exp_t e;
        e.pc = pc; e.v = v; e.instr = instr; e.pcp1 = pcp1; e.fc = fc; e.sc = sc;
        return e;
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic d,
                                input logic [31:0] t, input logic h, input exp_t e);
        vec_t x;
        x.rst = r; x.stall = s; x.redir = d; x.tgt = t; x.halt = h; x.e = e;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e,
                           input logic [31:0] pc, input logic v, input logic [31:0] instr,
                           input logic [31:0] pcp1, input logic [15:0] fc, input logic [15:0] sc);
        check({tag, ".pc"},    64'(pc),    64'(e.pc));
        check({tag, ".valid"}, 64'(v),     64'(e.v));
        check({tag, ".instr"}, 64'(instr), 64'(e.instr));
        check({tag, ".pcp1"},  64'(pcp1),  64'(e.pcp1));
        check({tag, ".fcnt"},  64'(fc),    64'(e.fc));
        check({tag, ".scnt"},  64'(sc),    64'(e.sc));
    endtask

    task automatic step_small(input string tag, input logic r, input logic s, input exp_t e);
        exp_t got;
        s_rst   = r;
        s_stall = s;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        cmp_all(tag, got, {28'b0, s_imem_addr}, s_id_valid, s_id_instr,
                {28'b0, s_id_pc_plus1}, {13'b0, s_fetch_count}, {13'b0, s_stall_count});
    endtask

    initial begin
        exp_t got;
        int   p;

        // inputs / expected state after the edge
        tbl[0]  = mk(1, 0, 0, 32'h0,  0, mk_e(32'h00, 0, 32'h000, 32'h00, 0, 0));
        tbl[1]  = mk(0, 0, 0, 32'h0,  0, mk_e(32'h01, 1, 32'h100, 32'h01, 1, 0));
        tbl[2]  = mk(0, 0, 0, 32'h0,  0, mk_e(32'h02, 1, 32'h101, 32'h02, 2, 0));
        tbl[3]  = mk(0, 0, 0, 32'h0,  0, mk_e(32'h03, 1, 32'h102, 32'h03, 3, 0));
        tbl[4]  = mk(0, 0, 0, 32'h0,  0, mk_e(32'h04, 1, 32'h103, 32'h04, 4, 0));
        tbl[5]  = mk(0, 0, 0, 32'h0,  0, mk_e(32'h05, 1, 32'h104, 32'h05, 5, 0));
        tbl[6]  = mk(0, 1, 0, 32'h0,  0, mk_e(32'h05, 1, 32'h104, 32'h05, 5, 1));
        tbl[7]  = mk(0, 1, 0, 32'h0,  0, mk_e(32'h05, 1, 32'h104, 32'h05, 5, 2));
        tbl[8]  = mk(0, 1, 0, 32'h0,  0, mk_e(32'h05, 1, 32'h104, 32'h05, 5, 3));
        tbl[9]  = mk(0, 0, 0, 32'h0,  0, mk_e(32'h06, 1, 32'h105, 32'h06, 6, 3));
        tbl[10] = mk(0, 0, 0, 32'h0,  0, mk_e(32'h07, 1, 32'h106, 32'h07, 7, 3));
        tbl[11] = mk(0, 1, 1, 32'h40, 0, mk_e(32'h40, 0, 32'h000, 32'h07, 7, 3));
        tbl[12] = mk(0, 0, 0, 32'h0,  0, mk_e(32'h41, 1, 32'h140, 32'h41, 8, 3));
        tbl[13] = mk(0, 0, 1, 32'h09, 0, mk_e(32'h09, 0, 32'h000, 32'h41, 8, 3));
        tbl[14] = mk(0, 0, 0, 32'h0,  1, mk_e(32'h09, 0, 32'h000, 32'h41, 8, 3));
        tbl[15] = mk(0, 0, 0, 32'h0,  1, mk_e(32'h09, 0, 32'h000, 32'h41, 8, 3));
        tbl[16] = mk(0, 0, 0, 32'h0,  0, mk_e(32'h0A, 1, 32'h109, 32'h0A, 9, 3));
        tbl[17] = mk(1, 1, 1, 32'h55, 1, mk_e(32'h00, 0, 32'h000, 32'h00, 0, 0));
        tbl[18] = mk(0, 0, 0, 32'h0,  0, mk_e(32'h01, 1, 32'h100, 32'h01, 1, 0));
        tbl[19] = mk(0, 1, 0, 32'h0,  1, mk_e(32'h01, 1, 32'h100, 32'h01, 1, 1));

        s_rst             = 1'b1;
        s_stall           = 1'b0;
        s_redirect_valid  = 1'b0;
        s_redirect_target = 4'd0;
        s_halt            = 1'b0;

        for (int i = 0; i < 20; i++) begin
            rst             = tbl[i].rst;
            stall           = tbl[i].stall;
            redirect_valid  = tbl[i].redir;
            redirect_target = tbl[i].tgt;
            halt            = tbl[i].halt;
            sb.push_back(tbl[i].e);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            cmp_all($sformatf("v%0d", i), got, imem_addr, id_valid, id_instr,
                    id_pc_plus1, fetch_count, stall_count);
        end

        // Narrow instance: reset to pc=13, ten fetches wrap 15->0 and
        // saturate fetch_count at 7; nine stalls saturate stall_count at 7.
        step_small("w_rst", 1'b1, 1'b0, mk_e(32'd13, 0, 32'h000, 32'd0, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            p = (13 + k) % 16;
            step_small($sformatf("w_fetch%0d", k), 1'b0, 1'b0,
                       mk_e(32'(p), 1, 32'h100 + 32'((12 + k) % 16), 32'(p),
                            16'((k > 7) ? 7 : k), 0));
        end
        for (int k = 1; k <= 9; k++) begin
            step_small($sformatf("w_stall%0d", k), 1'b0, 1'b1,
                       mk_e(32'd7, 1, 32'h106, 32'd7, 7, 16'((k > 7) ? 7 : k)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
